seq_mult_q88: RTL

//  Sequential signed fixed-point multiplier, Q8.8 by default, built on the 16-bit CLA adder.

---
 rtl/seq_mult_q88.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/seq_mult_q88.sv
// Signed fixed-point shift-add multiplier: one CLA addition per cycle over 16 iterations,
// then a sign/saturate cycle; valid/ready handshakes on both sides.
module seq_mult_q88 #(
  parameter int unsigned FRAC_BITS = 8,
  parameter bit          SATURATE  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

  state_e      state_q, state_d;
  logic [15:0] mcand_q, mcand_d;
  logic [15:0] acc_hi_q, acc_hi_d;
  logic [15:0] acc_lo_q, acc_lo_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic [15:0] out_data_q, out_data_d;
  logic        ovf_q, ovf_d;

  // 16-bit carry-lookahead adder: 4-bit groups with a second lookahead level.
  logic [15:0] cla_x, cla_y, cla_g, cla_p, cla_s;
  logic [16:0] cla_c;
  logic [3:0]  grp_g, grp_p;
  logic [4:0]  grp_c;

  assign cla_x = acc_hi_q;
  assign cla_y = acc_lo_q[0] ? mcand_q : 16'h0000;

  always_comb begin
    cla_c = '0;
    grp_c = '0;
    cla_g = cla_x & cla_y;
    cla_p = cla_x ^ cla_y;
    for (int k = 0; k < 4; k++) begin
      grp_p[k] = &cla_p[4*k +: 4];
      grp_g[k] = cla_g[4*k+3]
               | (cla_p[4*k+3] & cla_g[4*k+2])
               | (cla_p[4*k+3] & cla_p[4*k+2] & cla_g[4*k+1])
               | (cla_p[4*k+3] & cla_p[4*k+2] & cla_p[4*k+1] & cla_g[4*k]);
    end
    for (int k = 0; k < 4; k++) begin
      grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
    end
    for (int k = 0; k < 4; k++) begin
      cla_c[4*k] = grp_c[k];
      for (int j = 1; j < 4; j++) begin
        cla_c[4*k+j] = cla_g[4*k+j-1] | (cla_p[4*k+j-1] & cla_c[4*k+j-1]);
      end
    end
    cla_c[16] = grp_c[4];
    cla_s     = cla_p ^ cla_c[15:0];
  end

  // Result formatting, evaluated from the finished magnitude product.
  logic [31:0] prod, prod_sh;
  logic [15:0] mag_m, wrapped;
  logic        ovf_now;

  assign prod    = {acc_hi_q, acc_lo_q};
  assign prod_sh = prod >> FRAC_BITS;
  assign mag_m   = prod_sh[15:0];
  assign wrapped = neg_q ? (~mag_m + 16'd1) : mag_m;
  assign ovf_now = neg_q ? (prod_sh > 32'd32768) : (prod_sh > 32'd32767);

  always_comb begin
    // NOTE: every next-state value is defaulted to its current value first, so no path
    // through the case statement can leave a signal unassigned and infer a latch.
    state_d    = state_q;
    mcand_d    = mcand_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    out_data_d = out_data_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = a[15] ? (~a + 16'd1) : a;
          acc_lo_d = b[15] ? (~b + 16'd1) : b;
          acc_hi_d = 16'h0000;
          neg_d    = a[15] ^ b[15];
          cnt_d    = 4'd0;
          state_d  = RUN;
        end
      end
      RUN: begin
        {acc_hi_d, acc_lo_d} = {cla_c[16], cla_s, acc_lo_q[15:1]};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = FIX;
      end
      FIX: begin
        ovf_d      = ovf_now;
        out_data_d = wrapped;
        if (ovf_now && SATURATE) out_data_d = neg_q ? 16'h8000 : 16'h7FFF;
        state_d    = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are few and cheap, so all of them are cleared here,
      // which also guarantees no stale partial product survives an aborted operation.
      state_q    <= IDLE;
      mcand_q    <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      out_data_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      out_data_q <= out_data_d;
      ovf_q      <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_data_q;
  assign ovf       = ovf_q;

endmodule
